// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state encoding and MEM/WB register layout for the memory stage.
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } memState_t;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memToReg;
    logic [DATA_W-1:0]     aluOut;
    logic [DATA_W-1:0]     readData;
    logic [REG_ADDR_W-1:0] writeReg;
  } memWb_t;

  function automatic logic isMemOp(input logic valid, input logic load, input logic store);
    return valid & (load | store);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, contents not reset.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: fixed-latency data-memory access, upstream stall and the MEM/WB register.
//
// state   | meaning
// ST_IDLE | no access in flight; non-memory ops (and all ops at latency 1) complete here
// ST_BUSY | multi-cycle access in flight; cnt counts down to the completion cycle at cnt == 1
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validM,
  input  logic                  regWriteM,
  input  logic                  memToRegM,
  input  logic                  memWriteM,
  input  logic [DATA_W-1:0]     ALUOutM,
  input  logic [DATA_W-1:0]     writeDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  stallM,
  output logic                  validW,
  output logic                  regWriteW,
  output logic                  memToRegW,
  output logic [DATA_W-1:0]     ALUOutW,
  output logic [DATA_W-1:0]     readDataW,
  output logic [REG_ADDR_W-1:0] WriteRegW
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (MEM_LATENCY < 1) begin : gBadLatency
    $error("mem_stage: MEM_LATENCY must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
    $error("mem_stage: DEPTH must be a power of two, at least 2");
  end

  memState_t         state;
  logic [CNT_W-1:0]  cnt;
  memWb_t            wbReg;

  logic              memOp;
  logic              isStore;
  logic              isLoad;
  logic              complete;
  logic              memWe;
  logic [ADDR_W-1:0] wordAddr;
  logic [DATA_W-1:0] memRdata;

  // Byte offset and bits above the array size are dropped, so addresses wrap modulo DEPTH.
  assign wordAddr = ALUOutM[ADDR_W+1:2];
  assign memOp    = isMemOp(validM, memToRegM, memWriteM);
  assign isStore  = validM & memWriteM;
  assign isLoad   = memToRegM & ~memWriteM;

  always_comb begin
    stallM = 1'b0;
    if (state == ST_BUSY) begin
      stallM = (cnt != CNT_ONE);
    end else if (memOp && (MEM_LATENCY > 1)) begin
      stallM = 1'b1;
    end
  end

  assign complete = validM & ~stallM;
  // A store caught by reset is dropped even if its completion edge coincides with reset.
  assign memWe    = complete & isStore & ~rst;

  data_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uDataMem (
    .clk  (clk),
    .we   (memWe),
    .addr (wordAddr),
    .wdata(writeDataM),
    .rdata(memRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wbReg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memOp && (MEM_LATENCY > 1)) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (complete) begin
        wbReg.valid    <= 1'b1;
        wbReg.regWrite <= regWriteM;
        wbReg.memToReg <= isLoad;
        wbReg.aluOut   <= ALUOutM;
        wbReg.writeReg <= WriteRegM;
        if (isLoad) wbReg.readData <= memRdata;
      end else begin
        // Bubble: control bits cleared, data fields keep their last values.
        wbReg.valid    <= 1'b0;
        wbReg.regWrite <= 1'b0;
        wbReg.memToReg <= 1'b0;
      end
    end
  end

  assign validW    = wbReg.valid;
  assign regWriteW = wbReg.regWrite;
  assign memToRegW = wbReg.memToReg;
  assign ALUOutW   = wbReg.aluOut;
  assign readDataW = wbReg.readData;
  assign WriteRegW = wbReg.writeReg;

endmodule
